// File: rtl/fir_1d_5_s6_pkg.sv
// Shared constants for the five-tap systolic FIR: default widths, tap count,
// end-to-end latency and the X delay-line tap positions for slices 1..4.
package fir_1d_5_pkg;
    localparam int DEF_IN_WIDTH  = 18;
    localparam int DEF_OUT_WIDTH = 48;
    localparam int NUM_TAPS      = 5;
    localparam int LATENCY       = 6;
    localparam int MAX_DLY       = 7;
    localparam int TAP_DLY [1:NUM_TAPS-1] = '{1, 3, 5, 7};
endpackage

// File: rtl/fir_1d_5_s6_if.sv
// Sample/coefficient/cascade bundle of the FIR; master drives samples, slave is the filter.
interface fir_1d_5_s6_if
    import fir_1d_5_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
);
    logic                        CE;
    logic signed [IN_WIDTH-1:0]  H0, H1, H2, H3, H4;
    logic signed [IN_WIDTH-1:0]  X;
    logic                        X_STRB;
    logic signed [OUT_WIDTH-1:0] C;
    logic signed [OUT_WIDTH-1:0] PCIN;
    logic [7:0]                  OPMODE;
    logic signed [IN_WIDTH-1:0]  BCOUT;
    logic signed [OUT_WIDTH-1:0] Y;
    logic signed [OUT_WIDTH-1:0] PCOUT;
    logic                        Y_STRB;

    modport master (
        output CE, H0, H1, H2, H3, H4, X, X_STRB, C, PCIN, OPMODE,
        input  BCOUT, Y, PCOUT, Y_STRB
    );

    modport slave (
        input  CE, H0, H1, H2, H3, H4, X, X_STRB, C, PCIN, OPMODE,
        output BCOUT, Y, PCOUT, Y_STRB
    );
endinterface

// File: rtl/fir_1d_5_s6_dsp_slc.sv
// One multiply-accumulate slice: optional A0/B0 stage, A1/B1, M, P = M + addend.
// Latency 3 or 4 edges from A/B to P; no backpressure, CE low holds every register.
module dsp_slc
    import fir_1d_5_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        CE,
    input  logic signed [IN_WIDTH-1:0]  A,
    input  logic signed [IN_WIDTH-1:0]  B,
    input  logic signed [OUT_WIDTH-1:0] C,
    input  logic signed [OUT_WIDTH-1:0] PCIN,
    input  logic                        use_inreg0,
    input  logic                        use_pcin,
    output logic signed [IN_WIDTH-1:0]  BCOUT,
    output logic signed [OUT_WIDTH-1:0] P,
    output logic signed [OUT_WIDTH-1:0] PCOUT
);
    localparam int PW = 2 * IN_WIDTH;

    logic signed [IN_WIDTH-1:0]  a0_q, a0_d, b0_q, b0_d;
    logic signed [IN_WIDTH-1:0]  a1_q, a1_d, b1_q, b1_d;
    logic signed [PW-1:0]        m_q, m_d;
    logic signed [OUT_WIDTH-1:0] p_q, p_d;
    logic signed [PW-1:0]        a_ext, b_ext;
    logic signed [OUT_WIDTH-1:0] m_ext, addend;

    always_comb begin
        a_ext  = {{IN_WIDTH{a1_q[IN_WIDTH-1]}}, a1_q};
        b_ext  = {{IN_WIDTH{b1_q[IN_WIDTH-1]}}, b1_q};
        m_ext  = {{(OUT_WIDTH-PW){m_q[PW-1]}}, m_q};
        // Addend select is combinational so a mode change lands in the same cycle.
        addend = use_pcin ? PCIN : C;
        a0_d   = a0_q;
        b0_d   = b0_q;
        a1_d   = a1_q;
        b1_d   = b1_q;
        m_d    = m_q;
        p_d    = p_q;
        if (CE) begin
            a0_d = A;
            b0_d = B;
            a1_d = use_inreg0 ? a0_q : A;
            b1_d = use_inreg0 ? b0_q : B;
            m_d  = a_ext * b_ext;
            p_d  = m_ext + addend;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a0_q <= '0;
            b0_q <= '0;
            a1_q <= '0;
            b1_q <= '0;
            m_q  <= '0;
            p_q  <= '0;
        end else begin
            a0_q <= a0_d;
            b0_q <= b0_d;
            a1_q <= a1_d;
            b1_q <= b1_d;
            m_q  <= m_d;
            p_q  <= p_d;
        end
    end

    assign BCOUT = b1_q;
    assign P     = p_q;
    assign PCOUT = p_q;
endmodule

// File: rtl/fir_1d_5_s6.sv
// Five-tap systolic FIR of chained MAC slices; Y latency 6 enabled edges. No backpressure:
// CE low freezes every register. FIR_C_PORT_EN enables the C/PCIN select on OPMODE[3].
module fir_1d_5_s6
    import fir_1d_5_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic           CLK,
    input  logic           RST_N,
    fir_1d_5_s6_if.slave   bus
);
    logic signed [IN_WIDTH-1:0]  h       [NUM_TAPS];
    logic signed [IN_WIDTH-1:0]  b_in    [NUM_TAPS];
    logic signed [OUT_WIDTH-1:0] c_in    [NUM_TAPS];
    logic signed [OUT_WIDTH-1:0] pc_in   [NUM_TAPS];
    logic                        upc     [NUM_TAPS];
    logic signed [IN_WIDTH-1:0]  slc_bc  [NUM_TAPS];
    logic signed [OUT_WIDTH-1:0] slc_p   [NUM_TAPS];
    logic signed [OUT_WIDTH-1:0] slc_pc  [NUM_TAPS];
    logic signed [IN_WIDTH-1:0]  dly_q   [1:MAX_DLY];
    logic signed [IN_WIDTH-1:0]  dly_d   [1:MAX_DLY];
    logic [LATENCY:0]            strb_q, strb_d;
    logic                        slc0_use_pcin;
    logic signed [OUT_WIDTH-1:0] slc0_c;
    logic                        unused_slc;

    assign h[0] = bus.H0;
    assign h[1] = bus.H1;
    assign h[2] = bus.H2;
    assign h[3] = bus.H3;
    assign h[4] = bus.H4;

`ifdef FIR_C_PORT_EN
    assign slc0_use_pcin = ~bus.OPMODE[3];
    assign slc0_c        = bus.C;
`else
    assign slc0_use_pcin = 1'b1;
    assign slc0_c        = '0;
`endif

    // Strobe pipe is the sample-capture flop plus a 6-stage shift, so Y_STRB
    // lines up with the Y that carries H0 times the strobed sample.
    always_comb begin
        dly_d  = dly_q;
        strb_d = strb_q;
        if (bus.CE) begin
            dly_d[1] = bus.X;
            for (int k = 2; k <= MAX_DLY; k++) dly_d[k] = dly_q[k-1];
            strb_d = {strb_q[LATENCY-1:0], bus.X_STRB};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 1; k <= MAX_DLY; k++) dly_q[k] <= '0;
            strb_q <= '0;
        end else begin
            dly_q  <= dly_d;
            strb_q <= strb_d;
        end
    end

    for (genvar j = 0; j < NUM_TAPS; j++) begin : g_slc
        if (j == 0) begin : g_first
            assign b_in[j]  = bus.X;
            assign pc_in[j] = bus.PCIN;
            assign c_in[j]  = slc0_c;
            assign upc[j]   = slc0_use_pcin;
        end else begin : g_rest
            // Odd tap spacing offsets the extra input stage and the P-chain hop.
            assign b_in[j]  = dly_q[TAP_DLY[j]];
            assign pc_in[j] = slc_pc[j-1];
            assign c_in[j]  = '0;
            assign upc[j]   = 1'b1;
        end

        dsp_slc #(
            .IN_WIDTH  (IN_WIDTH),
            .OUT_WIDTH (OUT_WIDTH)
        ) u_slc (
            .CLK        (CLK),
            .RST_N      (RST_N),
            .CE         (bus.CE),
            .A          (h[j]),
            .B          (b_in[j]),
            .C          (c_in[j]),
            .PCIN       (pc_in[j]),
            .use_inreg0 (j != 0),
            .use_pcin   (upc[j]),
            .BCOUT      (slc_bc[j]),
            .P          (slc_p[j]),
            .PCOUT      (slc_pc[j])
        );
    end

    assign bus.Y      = slc_p[NUM_TAPS-1];
    assign bus.PCOUT  = slc_pc[NUM_TAPS-1];
    assign bus.BCOUT  = slc_bc[NUM_TAPS-1];
    assign bus.Y_STRB = strb_q[LATENCY];

    assign unused_slc = ^{slc_p[0], slc_p[1], slc_p[2], slc_p[3],
                          slc_bc[0], slc_bc[1], slc_bc[2], slc_bc[3]};
endmodule

// File: tb/tb_fir_1d_5_s6.sv
// Directed-vector bench for fir_1d_5_s6 with hand-computed expected outputs.
module tb_fir_1d_5_s6;
    import fir_1d_5_pkg::*;

    localparam int IW = DEF_IN_WIDTH;
    localparam int OW = DEF_OUT_WIDTH;

    logic CLK;
    logic RST_N;
    int   n_vec;
    int   n_err;

    fir_1d_5_s6_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

    fir_1d_5_s6 #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%h, expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic set_h(input int h0, input int h1, input int h2, input int h3, input int h4);
        bus.H0 = IW'(h0);
        bus.H1 = IW'(h1);
        bus.H2 = IW'(h2);
        bus.H3 = IW'(h3);
        bus.H4 = IW'(h4);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_y"},     bus.Y,          '0);
        chk({tag, "_pcout"}, bus.PCOUT,      '0);
        chk({tag, "_bcout"}, OW'(bus.BCOUT), '0);
        chk({tag, "_ystrb"}, OW'(bus.Y_STRB), '0);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        RST_N      = 1'b1;
        bus.CE     = 1'b1;
        bus.X      = '0;
        bus.X_STRB = 1'b0;
        bus.C      = '0;
        bus.PCIN   = '0;
        bus.OPMODE = 8'h00;
        set_h(0, 0, 0, 0, 0);

        // Reset from power-up, then idle with zero input.
        #2 RST_N = 1'b0;
        #1 chk_zero("rst_init");
        step(2);
        RST_N = 1'b1;
        step(8);
        chk("idle_y", bus.Y, '0);

        // Impulse through coefficients 1..5.
        set_h(1, 2, 3, 4, 5);
        step(4);
        bus.X      = IW'(1);
        bus.X_STRB = 1'b1;
        step(1);
        bus.X      = '0;
        bus.X_STRB = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            step(1);
            chk($sformatf("imp_y_%0d", k), bus.Y,
                (k >= 6 && k <= 10) ? OW'(k - 5) : OW'(0));
            chk($sformatf("imp_strb_%0d", k), OW'(bus.Y_STRB), OW'(k == 6));
            chk($sformatf("imp_bcout_%0d", k), OW'(bus.BCOUT), OW'(k == 8));
        end

        // Ramp with all taps 256; strobe raised with the first ramp sample.
        set_h(256, 256, 256, 256, 256);
        step(3);
        for (int k = 0; k <= 15; k++) begin
            bus.X      = IW'(k);
            bus.X_STRB = 1'b1;
            step(1);
            if (k == 5) chk("ramp_strb_pre", OW'(bus.Y_STRB), '0);
            if (k == 6) chk("ramp_strb_rise", OW'(bus.Y_STRB), OW'(1));
            if (k >= 10)
                chk($sformatf("ramp_y_%0d", k), bus.Y, OW'(256 * (5 * (k - 6) - 10)));
        end

        // Mid-stream reset clears outputs immediately, then zero history.
        RST_N = 1'b0;
        #2 chk_zero("rst_mid");
        bus.X      = '0;
        bus.X_STRB = 1'b0;
        step(1);
        RST_N = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk($sformatf("rst_rel_y_%0d", i), bus.Y, '0);
            chk($sformatf("rst_rel_strb_%0d", i), OW'(bus.Y_STRB), '0);
        end

        // DC level: 5 * 256 * 100 = 128000.
        bus.X      = IW'(100);
        bus.X_STRB = 1'b1;
        step(12);
        chk("dc_y",      bus.Y,          OW'(128000));
        chk("dc_pcout",  bus.PCOUT,      OW'(128000));
        chk("dc_y_hi",   OW'(bus.Y[31:16]), OW'(1));
        chk("dc_bcout",  OW'(bus.BCOUT), OW'(100));
        chk("dc_strb",   OW'(bus.Y_STRB), OW'(1));

        // Clock-enable low: inputs move, nothing inside may move.
        bus.CE     = 1'b0;
        bus.X      = IW'(5);
        bus.X_STRB = 1'b0;
        bus.PCIN   = OW'(999);
        step(6);
        chk("ce_y",     bus.Y,          OW'(128000));
        chk("ce_pcout", bus.PCOUT,      OW'(128000));
        chk("ce_bcout", OW'(bus.BCOUT), OW'(100));
        chk("ce_strb",  OW'(bus.Y_STRB), OW'(1));
        bus.CE     = 1'b1;
        bus.X      = IW'(100);
        bus.X_STRB = 1'b1;
        bus.PCIN   = '0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk($sformatf("ce_resume_y_%0d", i), bus.Y, OW'(128000));
            chk($sformatf("ce_resume_strb_%0d", i), OW'(bus.Y_STRB), OW'(1));
        end

        // Signed product and modulo-2^48 wrap of the cascade sum.
        set_h(-1, 0, 0, 0, 0);
        bus.X      = IW'(-131072);
        bus.X_STRB = 1'b0;
        step(12);
        chk("signed_y", bus.Y, OW'(131072));
        bus.X    = IW'(-1);
        bus.PCIN = 48'h7FFF_FFFF_FFFF;
        step(12);
        chk("wrap_y", bus.Y, 48'h8000_0000_0000);

        // Cascade addend selection.
        set_h(0, 0, 0, 0, 0);
        bus.X      = '0;
        bus.PCIN   = OW'(1000);
        bus.C      = OW'(7);
        bus.OPMODE = 8'h00;
        step(12);
        chk("casc_pcin_y",     bus.Y,     OW'(1000));
        chk("casc_pcin_pcout", bus.PCOUT, OW'(1000));
        bus.OPMODE = 8'h08;
        step(8);
`ifdef FIR_C_PORT_EN
        chk("casc_c_y",     bus.Y,     OW'(7));
        chk("casc_c_pcout", bus.PCOUT, OW'(7));
`else
        chk("casc_c_ign_y",     bus.Y,     OW'(1000));
        chk("casc_c_ign_pcout", bus.PCOUT, OW'(1000));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fir_1d_5_s6.md
# fir_1d_5_s6

Five-tap systolic FIR filter computing Y(n) = H0·x(n) + H1·x(n-1) + H2·x(n-2) + H3·x(n-3) + H4·x(n-4) + cascade term. It is built from five chained multiply-accumulate slices modelled on the Spartan-6 DSP48A1 pre-adder-less path. It sits in the pixel-filter datapath, and several instances can be cascaded through PCIN/PCOUT.

## Interface
- IN_WIDTH, 18, signed width of X, H0..H4 and BCOUT
- OUT_WIDTH, 48, signed width of C, PCIN, PCOUT and Y
- CLK  in  1  clock, all registers on the rising edge
- RST_N  in  1  asynchronous active-low reset
- CE  in  1  global clock enable for all data and strobe registers
- H0..H4  in  IN_WIDTH each  signed coefficients, static or quasi-static
- X  in  IN_WIDTH  signed sample, taken every enabled cycle
- X_STRB  in  1  sample-valid marker
- C  in  OUT_WIDTH  alternate addend for slice 0
- PCIN  in  OUT_WIDTH  cascade addend for slice 0
- OPMODE  in  8  only bit 3 is used: 0 selects PCIN, 1 selects C as the slice-0 addend
- BCOUT  out  IN_WIDTH  B-register output of slice 4
- Y  out  OUT_WIDTH  filter result (slice-4 P register)
- PCOUT  out  OUT_WIDTH  equal to Y, used for the cascade
- Y_STRB  out  1  X_STRB aligned to Y

## Operation
- Slice 0 has 3 register stages: operand register A1/B1, product register M, then P = M + addend.
- Slices 1–4 have 4 register stages: an extra input register A0/B0 ahead of A1/B1. Their addend is the previous slice's P.
- Slice j's B input is taken from an X delay line at 2j−1 registers (taps 1, 3, 5, 7). This aligns slice j's product with x(n−j) at the P stage.
- Arithmetic:
  - Product is the signed IN_WIDTH×IN_WIDTH result, sign-extended to OUT_WIDTH.
  - Sums are taken modulo 2^OUT_WIDTH, with no saturation.
- With RST_N low, every register clears to 0 immediately. This includes the delay line, all slice registers, and the strobe pipe, so Y, PCOUT, BCOUT and Y_STRB are all 0.
- With CE low, all registers hold, including the delay line and the strobe pipe.
- Coefficients are sampled in the A registers. A change to Hj takes effect on outputs only after Hj's pipeline depth.

## Timing
- Latency: X sampled at enabled edge e contributes H0·X to Y after enabled edge e+6.
- Full result: Y after edge e+6 equals Σ Hj·x(e−j) plus the addend sampled at edge e+2.
- Y_STRB passes through a 6-stage shift of X_STRB, so it is valid coincident with the matching Y.
- Deasserting RST_N mid-stream restarts from zero history. The first 6 enabled edges produce a partial-sum transient; Y_STRB stays 0 during it unless X_STRB was high.
- The OPMODE[3] select is applied at slice 0's P stage in the same cycle, and is not registered.

## Configuration
- FIR_C_PORT_EN:
  - Defined: OPMODE[3] selects between C and PCIN as described above.
  - Undefined: the C port and OPMODE are ignored and the slice-0 addend is always PCIN.

## Structure
- Package fir_1d_5_pkg holds:
  - default IN_WIDTH/OUT_WIDTH
  - NUM_TAPS=5
  - LATENCY=6
  - tap-delay constants (1, 3, 5, 7)
- Submodule dsp_slc is one MAC slice with ports CLK, RST_N, CE, A, B, C, PCIN, use_inreg0, use_pcin, BCOUT, P, PCOUT.
- The top instantiates dsp_slc five times, plus the X delay line and the strobe pipe.

## Test plan
- Reset: assert RST_N=0 mid-run → Y, PCOUT, BCOUT, Y_STRB all 0 at once. After release with X=0, Y stays 0.
- Impulse, H0..H4=1,2,3,4,5, PCIN=0, X=1 for one cycle, then 0:
  - Y = 1, 2, 3, 4, 5 on the 6th through 10th edges after sampling, then 0.
  - Y_STRB pulses with the first of these if X_STRB accompanied X.
- DC, all H=256, X held at 100 → steady Y=128000 (Y[31:16]=1).
- Ramp, all H=256, X=k counting → Y=256·(5k−10) for k≥4. Y_STRB rises 6 edges after X_STRB first goes high.
- Signed, H0=−1, others 0, X=−131072 → Y=+131072. PCIN=2^47−1 with H0·X=1 → Y wraps to −2^47.
- Cascade:
  - OPMODE[3]=0, PCIN=1000, X=0 → Y=1000.
  - OPMODE[3]=1, C=7 (FIR_C_PORT_EN defined) → Y=7. CE low → all outputs freeze.
